// File: rtl/group_fifo_reader.sv
// Consumer of the SFTM->DPM group FIFO: issues row reads, absorbs the one-cycle
// read latency in a skid buffer and re-presents rows as a tagged valid/ready stream.
module group_fifo_reader #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned GROUP_ROWS = 4,
    parameter int unsigned SKID_DEPTH = 2,
    parameter int unsigned GCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GCNT_W-1:0] num_groups,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_data_valid,
    input  logic              fifo_empty,
    input  logic              fifo_error,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              credit_return,
    output logic              busy,
    output logic              done,
    output logic [GCNT_W-1:0] groups_done,
    output logic              error
);

    localparam int unsigned RIW = (GROUP_ROWS > 1) ? $clog2(GROUP_ROWS) : 1;
    localparam int unsigned TW  = GCNT_W + RIW;
    localparam int unsigned PW  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned OW  = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     rows_total_q, rows_issued_q;
    logic [RIW-1:0]    row_idx_q;
    logic [GCNT_W-1:0] groups_done_q;
    logic              inflight_q, error_q, credit_q, done_q, quiet_q;
    logic [DATA_W-1:0] skid_mem [SKID_DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [OW-1:0]     occ_q;

    logic              pop, push, err_now, start_ok, skid_room, last_row_issue;
    logic [OW:0]       room_lhs, room_rhs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // pop is derived from occupancy directly so fifo_rd_en does not depend on out_valid
    always_comb begin
        pop            = (occ_q != '0) & out_ready;
        push           = fifo_rd_data_valid & inflight_q;
        err_now        = fifo_error
                       | (fifo_rd_data_valid & ~inflight_q & ~quiet_q)
                       | (inflight_q & ~fifo_rd_data_valid);
        start_ok       = start & (state_q == S_IDLE) & ~error_q;
        room_lhs       = (OW+1)'(occ_q) + (OW+1)'(inflight_q);
        room_rhs       = (OW+1)'(SKID_DEPTH) + (OW+1)'(pop);
        skid_room      = room_lhs < room_rhs;
        last_row_issue = (rows_issued_q + TW'(1)) == rows_total_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (err_now) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_ok && num_groups != '0) state_d = S_RUN;
                S_RUN:   if (fifo_rd_en && last_row_issue) state_d = S_DRAIN;
                S_DRAIN: if (!inflight_q && occ_q == OW'(pop)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_rd_en    = ~rst & (state_q == S_RUN) & ~fifo_empty & ~error_q
                      & (rows_issued_q < rows_total_q) & skid_room;
        busy          = (state_q != S_IDLE);
        out_valid     = (occ_q != '0);
        out_data      = out_valid ? skid_mem[rd_ptr_q] : '0;
        out_first     = (row_idx_q == '0);
        out_last      = (row_idx_q == RIW'(GROUP_ROWS - 1));
        credit_return = credit_q;
        done          = done_q;
        groups_done   = groups_done_q;
        error         = error_q;
    end

    // quiet_q masks the unsolicited-data check for a response still arriving after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_total_q  <= '0;
            rows_issued_q <= '0;
            row_idx_q     <= '0;
            groups_done_q <= '0;
            inflight_q    <= 1'b0;
            error_q       <= 1'b0;
            credit_q      <= 1'b0;
            done_q        <= 1'b0;
            quiet_q       <= 1'b1;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            occ_q         <= '0;
        end else begin
            quiet_q    <= 1'b0;
            error_q    <= error_q | err_now;
            inflight_q <= fifo_rd_en & ~err_now;
            credit_q   <= 1'b0;
            done_q     <= 1'b0;
            if (err_now) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                occ_q     <= '0;
                row_idx_q <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop) begin
                    rd_ptr_q  <= ptr_inc(rd_ptr_q);
                    row_idx_q <= out_last ? '0 : row_idx_q + RIW'(1);
                    if (out_last) begin
                        credit_q      <= 1'b1;
                        groups_done_q <= groups_done_q + GCNT_W'(1);
                    end
                end
                occ_q <= occ_q + OW'(push) - OW'(pop);
                if (fifo_rd_en) rows_issued_q <= rows_issued_q + TW'(1);
                if (state_q == S_DRAIN && state_d == S_IDLE) done_q <= 1'b1;
                if (start_ok) begin
                    if (num_groups == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        rows_total_q  <= TW'(num_groups) * TW'(GROUP_ROWS);
                        rows_issued_q <= '0;
                        row_idx_q     <= '0;
                        groups_done_q <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !err_now) skid_mem[wr_ptr_q] <= fifo_rd_data;
    end

endmodule

// File: tb/tb_group_fifo_reader.sv
// Bench for group_fifo_reader: queue-based FIFO model with registered read port and a
// stream-level reference (row order, group position tags, credits, done).
module tb_group_fifo_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned GR = 4;
    localparam int unsigned SD = 2;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [GW-1:0] num_groups;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_data_valid, fifo_empty, fifo_error;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_first, out_last;
    logic          credit_return, busy, done, error;
    logic [GW-1:0] groups_done;

    always #5 clk = ~clk;

    group_fifo_reader #(
        .DATA_W(DW), .GROUP_ROWS(GR), .SKID_DEPTH(SD), .GCNT_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_groups(num_groups),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_data_valid(fifo_rd_data_valid), .fifo_empty(fifo_empty),
        .fifo_error(fifo_error), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .credit_return(credit_return), .busy(busy), .done(done),
        .groups_done(groups_done), .error(error)
    );

    typedef struct {
        int unsigned ngroups;
        int unsigned extra;
        int unsigned ready_mode;
        int unsigned exp_rows;
        int unsigned exp_credits;
    } vec_t;

    vec_t          vecs [5];
    int unsigned   total = 0, bad = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    bit            rd_prev, drop_resp, check_stream, stall_prev;
    logic [DW-1:0] stall_data, seq_val;
    int            beat, credits, dones, outstanding, rd_cnt, cyc;
    int            start_cyc, first_rd_cyc, first_valid_cyc, last_pop_cyc;
    int            ready_mode, trickle_left, rd_mark, nwait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_row(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic sample();
        bit pop;
        pop = out_valid && out_ready;
        if (start) start_cyc = cyc;
        if (fifo_rd_en) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            check("rd_not_empty", fifo_q.size() != 0, 1);
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (check_stream) begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_data);
            end
            if (pop) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
                check("out_first", out_first, (beat % GR) == 0);
                check("out_last", out_last, (beat % GR) == GR - 1);
                beat++;
                last_pop_cyc = cyc;
            end
            outstanding = outstanding + int'(fifo_rd_en) - int'(pop);
            check("skid_bound", outstanding <= int'(SD), 1);
        end
        credits += int'(credit_return);
        dones   += int'(done);
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        rd_prev    = fifo_rd_en;
        cyc++;
    endtask

    task automatic drive();
        start              = 1'b0;
        fifo_rd_data_valid = 1'b0;
        fifo_rd_data       = '0;
        if (rd_prev) begin
            if (drop_resp) drop_resp = 1'b0;
            else if (fifo_q.size() != 0) begin
                fifo_rd_data       = fifo_q.pop_front();
                fifo_rd_data_valid = 1'b1;
            end
        end
        if (trickle_left > 0 && $urandom_range(0, 1) == 1) begin
            write_row(DW'($urandom));
            trickle_left--;
        end
        fifo_empty = (fifo_q.size() == 0);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_fifo();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rd_en_in_reset", rd_prev, 0);
        rst = 1'b0;
        outstanding = 0;
        stall_prev  = 1'b0;
        beat        = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_credit", credit_return, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_groups_done", groups_done, 0);
        check("rst_out_data", out_data, 0);
    endtask

    task automatic start_xfer(input int unsigned n);
        beat = 0; credits = 0; dones = 0;
        first_rd_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1;
        num_groups = GW'(n);
        start = 1'b1;
        tick();
    endtask

    task automatic run_until_done(input int limit);
        int n;
        n = 0;
        while (dones == 0 && n < limit) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("done_once", dones, 1);
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat < target && n < 200) begin
            tick();
            n++;
        end
        check("beats_reached", beat >= target, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{ngroups: 2, extra: 0, ready_mode: 0, exp_rows: 8,  exp_credits: 2};
        vecs[1] = '{ngroups: 2, extra: 0, ready_mode: 1, exp_rows: 8,  exp_credits: 2};
        vecs[2] = '{ngroups: 1, extra: 3, ready_mode: 2, exp_rows: 4,  exp_credits: 1};
        vecs[3] = '{ngroups: 3, extra: 1, ready_mode: 2, exp_rows: 12, exp_credits: 3};
        vecs[4] = '{ngroups: 1, extra: 0, ready_mode: 1, exp_rows: 4,  exp_credits: 1};

        rst = 1'b1; start = 1'b0; num_groups = '0;
        fifo_rd_data = '0; fifo_rd_data_valid = 1'b0; fifo_empty = 1'b1; fifo_error = 1'b0;
        out_ready = 1'b1; ready_mode = 0; check_stream = 1'b1;
        rd_prev = 1'b0; drop_resp = 1'b0; stall_prev = 1'b0; stall_data = '0; seq_val = '0;
        beat = 0; credits = 0; dones = 0; outstanding = 0; rd_cnt = 0; cyc = 0;
        start_cyc = 0; first_rd_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1;
        trickle_left = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Table-driven full transfers
        for (int i = 0; i < 5; i++) begin
            clear_fifo();
            ready_mode = int'(vecs[i].ready_mode);
            for (int unsigned r = 0; r < vecs[i].exp_rows + vecs[i].extra; r++) begin
                seq_val = seq_val + 1'b1;
                write_row(seq_val);
            end
            rd_mark = rd_cnt;
            start_xfer(vecs[i].ngroups);
            run_until_done(400);
            check("credits", credits, vecs[i].exp_credits);
            check("groups_done", groups_done, vecs[i].ngroups);
            check("rows_read", rd_cnt - rd_mark, vecs[i].exp_rows);
            check("rows_beats", beat, vecs[i].exp_rows);
            check("rows_left", exp_q.size(), vecs[i].extra);
            check("idle_after", busy, 0);
            if (vecs[i].ready_mode == 0) begin
                check("lat_start_rd", first_rd_cyc - start_cyc, 1);
                check("lat_rd_valid", first_valid_cyc - first_rd_cyc, 2);
                check("back_to_back", last_pop_cyc - first_valid_cyc, vecs[i].exp_rows - 1);
            end
        end

        // Zero groups: done next cycle, no reads, never busy
        clear_fifo();
        write_row(16'h1111);
        rd_mark = rd_cnt;
        start_xfer(0);
        check("zero_busy0", busy, 0);
        tick();
        check("zero_done", dones, 1);
        check("zero_busy1", busy, 0);
        repeat (3) tick();
        check("zero_no_rd", rd_cnt - rd_mark, 0);
        check("zero_done_once", dones, 1);

        // Partial group: FIFO runs dry, block waits in RUN
        clear_fifo();
        ready_mode = 0;
        write_row(16'hA001);
        write_row(16'hA002);
        start_xfer(1);
        repeat (12) tick();
        check("part_beats", beat, 2);
        check("part_busy", busy, 1);
        check("part_rd_idle", rd_prev, 0);
        check("part_no_done", dones, 0);
        check("part_no_credit", credits, 0);
        write_row(16'hA003);
        write_row(16'hA004);
        run_until_done(100);
        check("part_credit", credits, 1);
        check("part_beats_all", beat, 4);
        check("part_groups_done", groups_done, 1);

        // Underflow response: error sticky, reads stop until reset
        check_stream = 1'b0;
        clear_fifo();
        for (int r = 0; r < 4; r++) write_row(DW'($urandom));
        drop_resp = 1'b1;
        start_xfer(1);
        repeat (6) tick();
        check("uf_error", error, 1);
        check("uf_busy", busy, 0);
        check("uf_valid", out_valid, 0);
        check("uf_no_done", dones, 0);
        rd_mark = rd_cnt;
        start_xfer(1);
        repeat (8) tick();
        check("uf_no_rd", rd_cnt - rd_mark, 0);
        check("uf_sticky", error, 1);
        do_reset();

        // fifo_error mid-transfer
        clear_fifo();
        check_stream = 1'b1;
        ready_mode = 2;
        for (int r = 0; r < 8; r++) write_row(DW'($urandom));
        start_xfer(2);
        wait_beats(3);
        check_stream = 1'b0;
        fifo_error = 1'b1;
        tick();
        fifo_error = 1'b0;
        tick();
        rd_mark = rd_cnt;
        repeat (8) tick();
        check("fe_error", error, 1);
        check("fe_busy", busy, 0);
        check("fe_valid", out_valid, 0);
        check("fe_no_done", dones, 0);
        check("fe_no_rd", rd_cnt - rd_mark, 0);
        do_reset();
        check_stream = 1'b1;

        // Reset mid-group, stray response right after reset, then a clean transfer
        clear_fifo();
        ready_mode = 0;
        for (int r = 0; r < 4; r++) write_row(DW'($urandom));
        start_xfer(1);
        wait_beats(2);
        do_reset();
        clear_fifo();
        fifo_rd_data_valid = 1'b1;
        fifo_rd_data = 16'hBEEF;
        credits = 0; dones = 0;
        repeat (3) tick();
        check("mr_no_error", error, 0);
        check("mr_valid", out_valid, 0);
        check("mr_no_credit", credits, 0);
        check("mr_no_done", dones, 0);
        for (int r = 0; r < 4; r++) write_row(DW'($urandom));
        start_xfer(1);
        run_until_done(100);
        check("mr_credit", credits, 1);
        check("mr_beats", beat, 4);

        // Randomized transfers with trickling writes and random backpressure
        for (int it = 0; it < 6; it++) begin
            int unsigned ng, pre;
            ng = $urandom_range(1, 3);
            pre = $urandom_range(0, ng * GR);
            clear_fifo();
            ready_mode = 2;
            for (int unsigned r = 0; r < pre; r++) write_row(DW'($urandom));
            trickle_left = int'(ng * GR - pre);
            start_xfer(ng);
            run_until_done(800);
            check("rnd_credits", credits, ng);
            check("rnd_groups_done", groups_done, ng);
            check("rnd_beats", beat, ng * GR);
            check("rnd_drained", exp_q.size(), 0);
            trickle_left = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/group_fifo_reader.md
Name: group_fifo_reader

Overview:
DPM-side consumer of the SFTM->DPM group FIFO. It issues row reads into the FIFO's registered read port and absorbs the one-cycle read latency in a small skid buffer. Rows are re-presented to the DPM datapath as a valid/ready stream tagged with group first/last markers. One credit pulse goes back to SFTM per fully delivered group, and the block stops after a commanded number of groups.

Parameters:
DATA_W, 16, row data width; must match the FIFO.
GROUP_ROWS, 4, rows per group; must match the FIFO.
SKID_DEPTH, 2, output skid entries (>=2).
GCNT_W, 16, width of the group count and status counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle pulse; launches a transfer of num_groups groups (accepted in IDLE only).
num_groups  in  GCNT_W  group count, sampled on start.
fifo_rd_en  out  1  FIFO pop request; combinational.
fifo_rd_data  in  DATA_W  FIFO read data, valid with fifo_rd_data_valid.
fifo_rd_data_valid  in  1  FIFO read response, one cycle after fifo_rd_en.
fifo_empty  in  1  FIFO empty status.
fifo_error  in  1  FIFO overflow/underflow flag.
out_data  out  DATA_W  row to DPM.
out_valid  out  1  out_data valid.
out_ready  in  1  DPM accepts a row.
out_first  out  1  current row is row 0 of its group.
out_last  out  1  current row is row GROUP_ROWS-1 of its group.
credit_return  out  1  one-cycle pulse per group fully accepted downstream.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse on completion.
groups_done  out  GCNT_W  groups delivered in the current or last transfer.
error  out  1  sticky protocol error.

Behaviour:
- Reset values (rst=1 at posedge): state IDLE, skid empty, counters 0. out_valid, credit_return, done, error and busy are 0. out_data is 0. fifo_rd_en is 0 while rst=1.
- FSM states:
  - IDLE: on start with num_groups!=0, latch rows_total = num_groups*GROUP_ROWS (width GCNT_W+clog2(GROUP_ROWS)), clear groups_done and the row counters, then go to RUN. start with num_groups==0 pulses done the next cycle and stays in IDLE. start outside IDLE is ignored.
  - RUN: issues reads. Go to DRAIN when rows_issued reaches rows_total.
  - DRAIN: no further reads. Once the outstanding read has returned, the skid is empty and the last row has been accepted, pulse done and go to IDLE.
- Read issue: fifo_rd_en = (state==RUN) & !fifo_empty & !error & (rows_issued < rows_total) & (occ + inflight - pop < SKID_DEPTH).
  - occ is the skid occupancy; inflight = fifo_rd_en registered (0/1); pop = out_valid & out_ready.
  - This sustains 1 row/clk with out_ready held high.
- Latency: fifo_rd_en in cycle t, response in t+1, written into the skid at the end of t+1, out_valid in t+2.
- Skid: FIFO-ordered with SKID_DEPTH entries. out_data/out_valid are driven from the head entry. Push and pop in the same cycle keep occ unchanged. Overflow cannot occur by construction.
- Output tagging: row_idx counts 0..GROUP_ROWS-1 on each pop and wraps to 0.
  - out_first = (row_idx==0).
  - out_last = (row_idx==GROUP_ROWS-1).
  - Tags follow the head entry. They are not affected by backpressure.
- Credit: on a pop with out_last=1, credit_return pulses the next cycle and groups_done increments. out_valid and out_data are held stable while out_ready=0.
- Error (sticky; cleared only by rst) is set in any of these cases:
  - fifo_error=1.
  - fifo_rd_data_valid=1 with inflight=0 (unsolicited data).
  - inflight=1 with fifo_rd_data_valid=0 (underflow response).
- On error the FSM goes to IDLE the next cycle and the skid is flushed (out_valid=0). No done or credit pulse is issued. fifo_rd_en stays 0 until reset.
- A reset mid-transfer discards all state. It produces no credit or done pulse, and any FIFO response arriving in the cycle after reset is ignored.

Test Plan:
- GROUP_ROWS=4, FIFO preloaded with 8 rows 0x0001..0x0008, start num_groups=2, out_ready=1.
  - First fifo_rd_en in the cycle after start; first out_valid 2 cycles after that.
  - 8 consecutive beats; out_first on 0x0001 and 0x0005; out_last on 0x0004 and 0x0008.
  - credit_return pulses twice; done once; groups_done=2.
- Same transfer with out_ready toggling 1,0,0,1 repeatedly -> data order intact, out_data stable while stalled, at most 2 rows buffered, fifo_rd_en deasserted while the skid plus in-flight read is full.
- FIFO holds 2 rows and num_groups=1 -> 2 rows delivered, then the block waits in RUN with fifo_rd_en=0. Writing 2 more rows completes the group with one credit and done.
- start with num_groups=0 -> done pulse the next cycle, no fifo_rd_en, busy stays 0.
- Force fifo_rd_data_valid=0 one cycle after fifo_rd_en (underflow), and separately assert fifo_error -> error=1 and stays set, FSM in IDLE, out_valid=0, no further reads until rst.
- Assert rst mid-group (after 2 of 4 rows) -> all outputs return to reset values in the next cycle. A new start delivers from out_first with a clean row_idx.
